instr_parcel_issue: RTL and testbench
=====================================

Name: instr_parcel_issue

Overview:
- Upstream stage of the immediate-value generator and the other functional-unit sources.
- Accepts 16-bit instruction parcels from the instruction buffers and assembles one- and two-parcel instructions into CIP/LIP.
- Presents decoded fields (gh, i, j, k, m) with the instruction's parcel address, and holds the instruction until issue logic acknowledges it.
- Handles branch flush and reload of the parcel counter P.

Parameters:
- P_WIDTH, 24, width of the parcel-address counter P.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- i_parcel  input  16  next instruction parcel from instruction buffers
- i_parcel_valid  input  1  i_parcel is valid this cycle
- o_parcel_ready  output  1  block accepts i_parcel this cycle
- i_issue_ack  input  1  issue logic consumes the presented instruction this cycle
- i_flush  input  1  branch taken/exchange: discard contents, reload P
- i_new_p  input  P_WIDTH  parcel address loaded into P on i_flush
- o_issue_valid  output  1  complete instruction presented on field outputs
- o_instr  output  7  gh opcode field, CIP[15:9]
- o_cip_i  output  3  CIP[8:6]
- o_cip_j  output  3  CIP[5:3]
- o_cip_k  output  3  CIP[2:0]
- o_lip  output  16  second parcel (m field); 16'h0000 for one-parcel instructions
- o_two_parcel  output  1  presented instruction is two-parcel
- o_p  output  P_WIDTH  parcel address of the presented instruction's CIP

Behaviour:
- Parcel accepted when i_parcel_valid && o_parcel_ready at a rising edge.
- P increments by 1 (mod 2^P_WIDTH) per accepted parcel; P is the address of the next parcel to accept. The CIP address is captured into o_p when the CIP is accepted.
- Two-parcel opcodes (octal gh): 006, 007, 010–017, 020, 021, 040, 041, 100–137. All other opcodes are one-parcel.
- States:
  - EMPTY: o_parcel_ready=1. On accept, load CIP. Go to FULL if one-parcel (LIP cleared to 0), else NEED_LIP.
  - NEED_LIP: o_parcel_ready=1, o_issue_valid=0. On accept, load LIP and go to FULL.
  - FULL: o_issue_valid=1, o_parcel_ready=i_issue_ack.
    - On ack with a parcel accepted in the same cycle: that parcel becomes the new CIP; next state is FULL or NEED_LIP by its opcode.
    - On ack without a parcel: go to EMPTY.
    - Without ack: hold all outputs stable.
- Latency:
  - One-parcel instruction: o_issue_valid the cycle after its parcel is accepted.
  - Two-parcel instruction: o_issue_valid the cycle after its second parcel is accepted.
  - Back-to-back one-parcel instructions issue one per cycle when valid and ack are held high.
- Field outputs are registered and change only when a new CIP/LIP is loaded. Values while o_issue_valid=0 are don't-care, except that they are zero after reset.
- i_flush has priority over everything in the same cycle:
  - state → EMPTY, P ← i_new_p.
  - The parcel offered that cycle is not accepted; o_parcel_ready=0 during a flush cycle.
  - Any i_issue_ack in the flush cycle is ignored for state purposes; issue logic must not ack during flush.
  - A partially assembled two-parcel instruction (NEED_LIP) is discarded.
- Reset (async, rst=1): state EMPTY, P=0, all field outputs 0, o_issue_valid=0, o_two_parcel=0, o_p=0. o_parcel_ready=0 while rst is asserted, and 1 in the first cycle after deassertion.
- P wrap: P=2^P_WIDTH−1 followed by an accept gives P=0. A two-parcel instruction may straddle the wrap; o_p holds the CIP address.

Test Plan:
- Reset, then offer parcel 16'o020123 (gh=020, i=1, j=2, k=3), then 16'hBEEF → o_issue_valid rises one cycle after the second accept, with o_instr=7'o020, o_cip_j=2, o_cip_k=3, o_lip=16'hBEEF, o_two_parcel=1, o_p=0.
- Continuous stream of one-parcel instructions 16'o030000..16'o030007 with ack held high → eight issues on consecutive cycles; o_p=0..7; o_lip=0.
- Two-parcel 040 instruction held with i_issue_ack=0 for 5 cycles while parcels are offered → o_parcel_ready=0 and outputs stable; on ack, the next parcel is accepted in the same cycle.
- Flush in NEED_LIP state (CIP=16'o021000 accepted) with i_new_p=24'h000100 → state EMPTY, no issue; the next accepted parcel gives o_p=24'h000100.
- Flush and parcel_valid in the same cycle → parcel not accepted; P=i_new_p; the parcel is re-offered and accepted the next cycle.
- Flush to i_new_p=24'hFFFFFF, then a two-parcel 100 instruction → o_p=24'hFFFFFF and internal P wraps to 1 after the second parcel. Assert rst mid-assembly → all outputs zero immediately.

Source files
------------

// File: rtl/instr_parcel_issue_if.sv
// Parcel-issue interface: instruction-buffer parcel handshake on one side,
// decoded-instruction presentation and issue acknowledge on the other.
interface instr_parcel_issue_if #(
   parameter int P_WIDTH = 24
);
   logic [15:0]        i_parcel;
   logic               i_parcel_valid;
   logic               o_parcel_ready;
   logic               i_issue_ack;
   logic               i_flush;
   logic [P_WIDTH-1:0] i_new_p;
   logic               o_issue_valid;
   logic [6:0]         o_instr;
   logic [2:0]         o_cip_i;
   logic [2:0]         o_cip_j;
   logic [2:0]         o_cip_k;
   logic [15:0]        o_lip;
   logic               o_two_parcel;
   logic [P_WIDTH-1:0] o_p;

   // Upstream side: instruction buffers, issue logic and branch control.
   modport master (
      output i_parcel, i_parcel_valid, i_issue_ack, i_flush, i_new_p,
      input  o_parcel_ready, o_issue_valid, o_instr, o_cip_i, o_cip_j,
             o_cip_k, o_lip, o_two_parcel, o_p
   );

   // The parcel-issue block itself.
   modport slave (
      input  i_parcel, i_parcel_valid, i_issue_ack, i_flush, i_new_p,
      output o_parcel_ready, o_issue_valid, o_instr, o_cip_i, o_cip_j,
             o_cip_k, o_lip, o_two_parcel, o_p
   );
endinterface

// File: rtl/instr_parcel_issue.sv
// Instruction parcel issue: assembles 16-bit parcels into one- or two-parcel
// instructions (CIP/LIP), presents the decoded fields with the CIP parcel
// address, and holds them until issue logic acknowledges. A flush discards
// any partial or presented instruction and reloads the parcel counter P.
module instr_parcel_issue #(
   parameter int P_WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   instr_parcel_issue_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_EMPTY    = 2'd0,
      ST_NEED_LIP = 2'd1,
      ST_FULL     = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic               parcel_ready;
   logic               accept;
   logic               load_cip;
   logic               load_lip;
   logic               new_two;
   logic [15:0]        cip_q;
   logic [15:0]        lip_q;
   logic               two_q;
   logic [P_WIDTH-1:0] p_q;
   logic [P_WIDTH-1:0] cip_p_q;

   // Two-parcel opcodes (octal): 006-007, 010-017, 020-021, 040-041, 100-137.
   function automatic logic is_two_parcel(input logic [6:0] gh);
      return (gh[6:5] == 2'b10)      // 100-137
          || (gh[6:3] == 4'b0001)    // 010-017
          || (gh[6:1] == 6'b000011)  // 006-007
          || (gh[6:1] == 6'b001000)  // 020-021
          || (gh[6:1] == 6'b010000); // 040-041
   endfunction

   assign new_two = is_two_parcel(bus.i_parcel[15:9]);

   // Handshake, load strobes and next state; flush overrides everything.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
      state_d      = state_q;
      parcel_ready = 1'b0;
      load_cip     = 1'b0;
      load_lip     = 1'b0;

      if (!rst && !bus.i_flush) begin
         unique case (state_q)
            ST_EMPTY, ST_NEED_LIP: parcel_ready = 1'b1;
            ST_FULL:               parcel_ready = bus.i_issue_ack;
            default:               parcel_ready = 1'b0;
         endcase
      end

      accept = bus.i_parcel_valid && parcel_ready;

      if (bus.i_flush) begin
         state_d = ST_EMPTY;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  load_cip = 1'b1;
                  state_d  = new_two ? ST_NEED_LIP : ST_FULL;
               end
            end
            ST_NEED_LIP: begin
               if (accept) begin
                  load_lip = 1'b1;
                  state_d  = ST_FULL;
               end
            end
            ST_FULL: begin
               if (bus.i_issue_ack) begin
                  if (accept) begin
                     load_cip = 1'b1;
                     state_d  = new_two ? ST_NEED_LIP : ST_FULL;
                  end else begin
                     state_d = ST_EMPTY;
                  end
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (rst) state_q <= ST_EMPTY;
      else     state_q <= state_d;
   end

   // Parcel counter and instruction field registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q     <= '0;
         cip_q   <= '0;
         lip_q   <= '0;
         two_q   <= 1'b0;
         cip_p_q <= '0;
      end else begin
         if (bus.i_flush)  p_q <= bus.i_new_p;
         else if (accept)  p_q <= p_q + P_WIDTH'(1);

         if (load_cip) begin
            cip_q   <= bus.i_parcel;
            lip_q   <= '0;
            two_q   <= new_two;
            cip_p_q <= p_q;
         end
         if (load_lip) lip_q <= bus.i_parcel;
      end
   end

   assign bus.o_parcel_ready = parcel_ready;
   assign bus.o_issue_valid  = (state_q == ST_FULL);
   assign bus.o_instr        = cip_q[15:9];
   assign bus.o_cip_i        = cip_q[8:6];
   assign bus.o_cip_j        = cip_q[5:3];
   assign bus.o_cip_k        = cip_q[2:0];
   assign bus.o_lip          = lip_q;
   assign bus.o_two_parcel   = two_q;
   assign bus.o_p            = cip_p_q;

endmodule

// File: tb/tb_instr_parcel_issue.sv
// Testbench for instr_parcel_issue: directed scenarios plus a randomized run
// checked against an instruction-level reference model.
module tb_instr_parcel_issue;
   localparam int PW = 24;
   localparam int FW = 33 + PW;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   instr_parcel_issue_if #(.P_WIDTH(PW)) bus ();

   instr_parcel_issue #(.P_WIDTH(PW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: presented instruction, partial instruction, next P.
   bit            m_full;
   bit            m_half;
   bit            m_two;
   logic [15:0]   m_cip;
   logic [15:0]   m_lip;
   logic [PW-1:0] m_ip;
   logic [PW-1:0] m_p;

   function automatic bit spec_two(input logic [6:0] gh);
      return gh inside {7'o006, 7'o007, [7'o010:7'o017], 7'o020, 7'o021,
                        7'o040, 7'o041, [7'o100:7'o137]};
   endfunction

   function automatic bit m_ready();
      return !rst && !bus.i_flush && (!m_full || bus.i_issue_ack);
   endfunction

   function automatic void m_reset();
      m_full = 1'b0; m_half = 1'b0; m_two = 1'b0;
      m_cip  = '0;   m_lip  = '0;   m_ip  = '0; m_p = '0;
   endfunction

   function automatic void m_clock();
      bit acc;
      if (bus.i_flush) begin
         m_full = 1'b0;
         m_half = 1'b0;
         m_p    = bus.i_new_p;
         return;
      end
      acc = bus.i_parcel_valid && m_ready();
      if (m_full && bus.i_issue_ack) m_full = 1'b0;
      if (acc) begin
         if (m_half) begin
            m_lip  = bus.i_parcel;
            m_half = 1'b0;
            m_full = 1'b1;
         end else begin
            m_cip  = bus.i_parcel;
            m_lip  = '0;
            m_ip   = m_p;
            m_two  = spec_two(bus.i_parcel[15:9]);
            m_half = m_two;
            m_full = !m_two;
         end
         m_p = m_p + PW'(1);
      end
   endfunction

   function automatic logic [FW-1:0] dut_fields();
      return {bus.o_instr, bus.o_cip_i, bus.o_cip_j, bus.o_cip_k,
              bus.o_lip, bus.o_two_parcel, bus.o_p};
   endfunction

   function automatic logic [FW-1:0] exp_fields(input logic [15:0] cip, input logic [15:0] lip,
                                                input logic two, input logic [PW-1:0] p);
      return {cip, lip, two, p};
   endfunction

   task automatic drive(input bit v, input logic [15:0] pc, input bit a,
                        input bit f, input logic [PW-1:0] np);
      @(negedge clk);
      bus.i_parcel_valid = v;
      bus.i_parcel       = pc;
      bus.i_issue_ack    = a;
      bus.i_flush        = f;
      bus.i_new_p        = np;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      m_clock();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.i_parcel_valid = 1'b0; bus.i_parcel = '0; bus.i_issue_ack = 1'b0;
      bus.i_flush = 1'b0; bus.i_new_p = '0;
      m_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (bus.o_parcel_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready_low: got %b want 0", bus.o_parcel_ready);
      end
      checks++;
      if (bus.o_issue_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b want 0", bus.o_issue_valid);
      end
      checks++;
      if (dut_fields() !== '0) begin
         errors++; $display("FAIL reset_fields: got %h want 0", dut_fields());
      end
      @(negedge clk);
      rst = 1'b0;
      m_reset();
      #1;
      checks++;
      if (bus.o_parcel_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready_after: got %b want 1", bus.o_parcel_ready);
      end
   endtask

   task automatic test_two_parcel();
      do_reset();
      drive(1, 16'o020123, 0, 0, '0); tick();
      drive(1, 16'hBEEF, 0, 0, '0);
      checks++;
      if (bus.o_issue_valid !== 1'b0 || bus.o_parcel_ready !== 1'b1) begin
         errors++; $display("FAIL two_parcel_need_lip: got valid=%b ready=%b want valid=0 ready=1",
                            bus.o_issue_valid, bus.o_parcel_ready);
      end
      tick();
      drive(0, '0, 0, 0, '0);
      checks++;
      if (bus.o_issue_valid !== 1'b1) begin
         errors++; $display("FAIL two_parcel_valid: got %b want 1", bus.o_issue_valid);
      end
      checks++;
      if (dut_fields() !== exp_fields(16'o020123, 16'hBEEF, 1'b1, '0)) begin
         errors++; $display("FAIL two_parcel_fields: got %h want %h", dut_fields(),
                            exp_fields(16'o020123, 16'hBEEF, 1'b1, '0));
      end
      tick();
      drive(0, '0, 1, 0, '0); tick();
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int n = 0; n <= 8; n++) begin
         drive(n < 8, 16'o030000 + 16'(n), 1, 0, '0);
         if (n < 8) begin
            checks++;
            if (bus.o_parcel_ready !== 1'b1) begin
               errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", n, bus.o_parcel_ready);
            end
         end
         if (n > 0) begin
            checks++;
            if (bus.o_issue_valid !== 1'b1 ||
                dut_fields() !== exp_fields(16'o030000 + 16'(n - 1), 16'h0, 1'b0, PW'(n - 1))) begin
               errors++; $display("FAIL b2b_issue[%0d]: got valid=%b fields=%h want valid=1 fields=%h",
                                  n - 1, bus.o_issue_valid, dut_fields(),
                                  exp_fields(16'o030000 + 16'(n - 1), 16'h0, 1'b0, PW'(n - 1)));
            end
         end
         tick();
      end
      drive(0, '0, 0, 0, '0);
      checks++;
      if (bus.o_issue_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_drain: got %b want 0", bus.o_issue_valid);
      end
   endtask

   task automatic test_stall();
      do_reset();
      drive(1, 16'o040777, 0, 0, '0); tick();
      drive(1, 16'h1234, 0, 0, '0); tick();
      for (int c = 0; c < 5; c++) begin
         drive(1, 16'($urandom), 0, 0, '0);
         checks++;
         if (bus.o_parcel_ready !== 1'b0 || bus.o_issue_valid !== 1'b1 ||
             dut_fields() !== exp_fields(16'o040777, 16'h1234, 1'b1, '0)) begin
            errors++; $display("FAIL stall_hold[%0d]: got ready=%b valid=%b fields=%h want ready=0 valid=1 fields=%h",
                               c, bus.o_parcel_ready, bus.o_issue_valid, dut_fields(),
                               exp_fields(16'o040777, 16'h1234, 1'b1, '0));
         end
         tick();
      end
      drive(1, 16'o030001, 1, 0, '0);
      checks++;
      if (bus.o_parcel_ready !== 1'b1) begin
         errors++; $display("FAIL stall_ack_ready: got %b want 1", bus.o_parcel_ready);
      end
      tick();
      drive(0, '0, 0, 0, '0);
      checks++;
      if (bus.o_issue_valid !== 1'b1 || dut_fields() !== exp_fields(16'o030001, 16'h0, 1'b0, PW'(2))) begin
         errors++; $display("FAIL stall_next: got valid=%b fields=%h want valid=1 fields=%h",
                            bus.o_issue_valid, dut_fields(), exp_fields(16'o030001, 16'h0, 1'b0, PW'(2)));
      end
      tick();
      drive(0, '0, 1, 0, '0); tick();
   endtask

   task automatic test_flush_need_lip();
      do_reset();
      drive(1, 16'o021000, 0, 0, '0); tick();
      drive(0, '0, 0, 1, 24'h000100);
      checks++;
      if (bus.o_parcel_ready !== 1'b0) begin
         errors++; $display("FAIL flush_ready: got %b want 0", bus.o_parcel_ready);
      end
      tick();
      drive(0, '0, 0, 0, '0);
      checks++;
      if (bus.o_issue_valid !== 1'b0 || bus.o_parcel_ready !== 1'b1) begin
         errors++; $display("FAIL flush_empty: got valid=%b ready=%b want valid=0 ready=1",
                            bus.o_issue_valid, bus.o_parcel_ready);
      end
      tick();
      drive(1, 16'o030005, 0, 0, '0); tick();
      drive(0, '0, 0, 0, '0);
      checks++;
      if (bus.o_issue_valid !== 1'b1 || dut_fields() !== exp_fields(16'o030005, 16'h0, 1'b0, 24'h000100)) begin
         errors++; $display("FAIL flush_new_p: got valid=%b fields=%h want valid=1 fields=%h",
                            bus.o_issue_valid, dut_fields(), exp_fields(16'o030005, 16'h0, 1'b0, 24'h000100));
      end
      tick();
      drive(0, '0, 1, 0, '0); tick();
   endtask

   task automatic test_flush_with_valid();
      do_reset();
      drive(1, 16'o030002, 0, 1, 24'h000ABC);
      checks++;
      if (bus.o_parcel_ready !== 1'b0) begin
         errors++; $display("FAIL flushv_ready: got %b want 0", bus.o_parcel_ready);
      end
      tick();
      drive(1, 16'o030002, 0, 0, '0);
      checks++;
      if (bus.o_issue_valid !== 1'b0 || bus.o_parcel_ready !== 1'b1) begin
         errors++; $display("FAIL flushv_reoffer: got valid=%b ready=%b want valid=0 ready=1",
                            bus.o_issue_valid, bus.o_parcel_ready);
      end
      tick();
      drive(1, 16'o030003, 1, 0, '0);
      checks++;
      if (bus.o_issue_valid !== 1'b1 || dut_fields() !== exp_fields(16'o030002, 16'h0, 1'b0, 24'h000ABC)) begin
         errors++; $display("FAIL flushv_issue: got valid=%b fields=%h want valid=1 fields=%h",
                            bus.o_issue_valid, dut_fields(), exp_fields(16'o030002, 16'h0, 1'b0, 24'h000ABC));
      end
      tick();
      drive(0, '0, 1, 0, '0);
      checks++;
      if (bus.o_p !== 24'h000ABD) begin
         errors++; $display("FAIL flushv_next_p: got %h want 000abd", bus.o_p);
      end
      tick();
   endtask

   task automatic test_wrap_and_reset();
      do_reset();
      drive(0, '0, 0, 1, 24'hFFFFFF); tick();
      drive(1, 16'o100000, 0, 0, '0); tick();
      drive(1, 16'h5A5A, 0, 0, '0); tick();
      drive(1, 16'o030004, 1, 0, '0);
      checks++;
      if (bus.o_issue_valid !== 1'b1 || dut_fields() !== exp_fields(16'o100000, 16'h5A5A, 1'b1, 24'hFFFFFF)) begin
         errors++; $display("FAIL wrap_straddle: got valid=%b fields=%h want valid=1 fields=%h",
                            bus.o_issue_valid, dut_fields(), exp_fields(16'o100000, 16'h5A5A, 1'b1, 24'hFFFFFF));
      end
      tick();
      drive(1, 16'o006000, 1, 0, '0);
      checks++;
      if (bus.o_p !== 24'h000001) begin
         errors++; $display("FAIL wrap_p: got %h want 000001", bus.o_p);
      end
      tick();
      // Now mid-assembly of a two-parcel instruction; reset asynchronously.
      @(negedge clk);
      bus.i_parcel_valid = 1'b0; bus.i_issue_ack = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.o_parcel_ready !== 1'b0 || bus.o_issue_valid !== 1'b0 || dut_fields() !== '0) begin
         errors++; $display("FAIL async_reset: got ready=%b valid=%b fields=%h want all 0",
                            bus.o_parcel_ready, bus.o_issue_valid, dut_fields());
      end
      m_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (bus.o_parcel_ready !== 1'b1 || bus.o_issue_valid !== 1'b0) begin
         errors++; $display("FAIL async_reset_release: got ready=%b valid=%b want ready=1 valid=0",
                            bus.o_parcel_ready, bus.o_issue_valid);
      end
   endtask

   task automatic test_random();
      bit            v, a, f;
      logic [15:0]   pc;
      logic [PW-1:0] np;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         v  = ($urandom_range(0, 3) != 0);
         pc = 16'($urandom);
         f  = ($urandom_range(0, 31) == 0);
         a  = f ? 1'b0 : ($urandom_range(0, 2) != 0);
         np = ($urandom_range(0, 1) != 0) ? PW'(24'hFFFFFF - 24'($urandom_range(0, 3))) : PW'($urandom);
         drive(v, pc, a, f, np);
         checks++;
         if (bus.o_parcel_ready !== m_ready() || bus.o_issue_valid !== m_full) begin
            errors++; $display("FAIL rand_handshake[%0d]: got ready=%b valid=%b want ready=%b valid=%b",
                               c, bus.o_parcel_ready, bus.o_issue_valid, m_ready(), m_full);
         end
         if (m_full) begin
            checks++;
            if (dut_fields() !== exp_fields(m_cip, m_lip, m_two, m_ip)) begin
               errors++; $display("FAIL rand_fields[%0d]: got %h want %h",
                                  c, dut_fields(), exp_fields(m_cip, m_lip, m_two, m_ip));
            end
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.i_parcel_valid = 1'b0; bus.i_parcel = '0; bus.i_issue_ack = 1'b0;
      bus.i_flush = 1'b0; bus.i_new_p = '0;
      m_reset();
      test_reset();
      test_two_parcel();
      test_back_to_back();
      test_stall();
      test_flush_need_lip();
      test_flush_with_valid();
      test_wrap_and_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
